// File: rtl/bist_pkg.sv
// bist_pkg: shared widths, compare-pipeline entry type and BIST sequencer state encodings.
package bist_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] exp;
    logic [ADDR_W-1:0] addr;
  } pipe_entry_t;

  typedef enum logic [2:0] {
    STANDBY   = 3'b001,
    WR_UP     = 3'b010,
    READ_DOWN = 3'b011,
    WR_DOWN   = 3'b100,
    READ_UP   = 3'b101
  } seq_state_e;

endpackage

// File: rtl/bist_mem_datapath_if.sv
// bist_mem_datapath_if: SRAM-side bus between the BIST datapath (master) and the memory under test (slave).
// mem_we/mem_re are single-cycle strobes with no backpressure: a write is taken on the edge ending a
// cycle with mem_we high, and mem_rdata is valid exactly RD_LAT cycles after a cycle with mem_re high.
interface bist_mem_datapath_if #(
  parameter int ADDR_W = bist_pkg::ADDR_W,
  parameter int DATA_W = bist_pkg::DATA_W
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_we, output mem_re, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, input mem_re, output mem_rdata);
endinterface

// File: rtl/bist_addr_counter.sv
// bist_addr_counter: address register with reset/preset/up-down count and combinational terminal count.
module bist_addr_counter #(
  parameter int ADDR_W = bist_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              rst_adr,
  input  logic              pr_res_adr,
  input  logic              up_down,
  output logic [ADDR_W-1:0] addr,
  output logic              c_out
);
  localparam logic [ADDR_W-1:0] MAX = '1;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // rst_adr beats pr_res_adr, both beat counting; the count wraps modulo 2**ADDR_W.
  always_comb begin
    addr_d = addr_q;
    if (rst_adr)         addr_d = '0;
    else if (pr_res_adr) addr_d = MAX;
    else if (enable)     addr_d = up_down ? addr_q + ONE : addr_q - ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign addr  = addr_q;
  assign c_out = enable & ~rst_adr & ~pr_res_adr & (up_down ? (addr_q == MAX) : (addr_q == '0));
endmodule

// File: rtl/bist_mem_datapath.sv
// bist_mem_datapath: BIST memory-side datapath -- address counter, pattern drive, RD_LAT-deep read compare.
// Optional first-failure log (fail_valid/fail_addr/fail_data) is built when BIST_FAIL_LOG_EN is defined.
module bist_mem_datapath #(
  parameter int ADDR_W = bist_pkg::ADDR_W,
  parameter int DATA_W = bist_pkg::DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic rst_adr,
  input  logic pr_res_adr,
  input  logic up_down,
  input  logic data_bit,
  input  logic wr_en,
  input  logic read_en,
  output logic c_out,
  output logic error,
  output logic cmp_busy,
`ifdef BIST_FAIL_LOG_EN
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
`endif
  bist_mem_datapath_if.master mem
);
  import bist_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] pattern;
  logic              rd_issue;
  pipe_entry_t       pipe_q [RD_LAT];
  pipe_entry_t       pipe_d [RD_LAT];
  pipe_entry_t       cmp;
  logic              mismatch;
  logic              error_q, error_d;
  logic              err_vld_q, err_vld_d;
  logic              busy;

  bist_addr_counter #(.ADDR_W(ADDR_W)) u_addr_counter (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .rst_adr    (rst_adr),
    .pr_res_adr (pr_res_adr),
    .up_down    (up_down),
    .addr       (addr),
    .c_out      (c_out)
  );

  assign pattern       = {DATA_W{data_bit}};
  assign rd_issue      = read_en & enable;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = pattern;
  assign mem.mem_we    = wr_en & enable;
  assign mem.mem_re    = rd_issue;

  // The last pipeline stage lines up with mem_rdata; err_vld tracks the cycle its error flag is visible.
  always_comb begin
    pipe_d[0] = '{valid: rd_issue, exp: pattern, addr: addr};
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
    cmp       = pipe_q[RD_LAT-1];
    mismatch  = cmp.valid && (mem.mem_rdata != cmp.exp);
    error_d   = mismatch;
    err_vld_d = cmp.valid;
    busy      = err_vld_q;
    for (int i = 0; i < RD_LAT; i++) busy = busy | pipe_q[i].valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
      error_q   <= 1'b0;
      err_vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= pipe_d[i];
      error_q   <= error_d;
      err_vld_q <= err_vld_d;
    end
  end

  assign error    = error_q;
  assign cmp_busy = busy;

`ifdef BIST_FAIL_LOG_EN
  logic              fail_valid_q, fail_valid_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;

  // Only the first mismatch since reset is recorded; later ones leave the log untouched.
  always_comb begin
    fail_valid_d = fail_valid_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    if (mismatch && !fail_valid_q) begin
      fail_valid_d = 1'b1;
      fail_addr_d  = cmp.addr;
      fail_data_d  = mem.mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_valid_q <= 1'b0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
    end else begin
      fail_valid_q <= fail_valid_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_addr  = fail_addr_q;
  assign fail_data  = fail_data_q;
`endif
endmodule

// File: tb/tb_bist_mem_datapath.sv
// tb_bist_mem_datapath: RD_LAT=1 and RD_LAT=3 instances driven by the same strobes, checked every cycle
// against a cycle-indexed reference (integer address, reference memory, scheduled error cycles).
`timescale 1ns/1ps
module tb_bist_mem_datapath;
  import bist_pkg::*;

  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int NCYC = 4096;

  logic clk = 1'b0;
  logic rst;
  logic enable, rst_adr, pr_res_adr, up_down, data_bit, wr_en, read_en;

  logic [1:0]         cout_o, err_o, busy_o, we_o, re_o, fv_o;
  logic [1:0][AW-1:0] addr_o, fa_o;
  logic [1:0][DW-1:0] wd_o, fd_o;

  bist_mem_datapath_if #(.ADDR_W(AW), .DATA_W(DW)) mif1 ();
  bist_mem_datapath_if #(.ADDR_W(AW), .DATA_W(DW)) mif3 ();

  always #5 clk = ~clk;

  bist_mem_datapath #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .rst_adr(rst_adr), .pr_res_adr(pr_res_adr),
    .up_down(up_down), .data_bit(data_bit), .wr_en(wr_en), .read_en(read_en),
    .c_out(cout_o[0]), .error(err_o[0]), .cmp_busy(busy_o[0]),
`ifdef BIST_FAIL_LOG_EN
    .fail_valid(fv_o[0]), .fail_addr(fa_o[0]), .fail_data(fd_o[0]),
`endif
    .mem(mif1)
  );

  bist_mem_datapath #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .rst_adr(rst_adr), .pr_res_adr(pr_res_adr),
    .up_down(up_down), .data_bit(data_bit), .wr_en(wr_en), .read_en(read_en),
    .c_out(cout_o[1]), .error(err_o[1]), .cmp_busy(busy_o[1]),
`ifdef BIST_FAIL_LOG_EN
    .fail_valid(fv_o[1]), .fail_addr(fa_o[1]), .fail_data(fd_o[1]),
`endif
    .mem(mif3)
  );

`ifndef BIST_FAIL_LOG_EN
  assign fv_o = '0;
  assign fa_o = '0;
  assign fd_o = '0;
`endif

  assign addr_o[0] = mif1.mem_addr;  assign addr_o[1] = mif3.mem_addr;
  assign wd_o[0]   = mif1.mem_wdata; assign wd_o[1]   = mif3.mem_wdata;
  assign we_o[0]   = mif1.mem_we;    assign we_o[1]   = mif3.mem_we;
  assign re_o[0]   = mif1.mem_re;    assign re_o[1]   = mif3.mem_re;

  // ---------------- SRAM under test with stuck-at fault masks ----------------
  logic [DW-1:0] sram [8];
  logic [DW-1:0] sa0 [8];
  logic [DW-1:0] sa1 [8];
  logic [DW-1:0] rp1;
  logic [DW-1:0] rp3 [3];

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
    return (v & ~sa0[a]) | sa1[a];
  endfunction

  always @(posedge clk) begin
    if (mif1.mem_we) sram[mif1.mem_addr] <= mif1.mem_wdata;
    rp1    <= faulty(sram[mif1.mem_addr], int'(mif1.mem_addr));
    rp3[0] <= faulty(sram[mif3.mem_addr], int'(mif3.mem_addr));
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end

  assign mif1.mem_rdata = rp1;
  assign mif3.mem_rdata = rp3[2];

  // ---------------- reference model ----------------
  int            m_addr;
  int            cyc;
  int            last_rd;
  logic [DW-1:0] ref_mem [8];
  bit            exp_err [2][NCYC];
  logic [AW-1:0] ea [2][NCYC];
  logic [DW-1:0] ed [2][NCYC];
  bit            m_fv [2];
  logic [AW-1:0] m_fa [2];
  logic [DW-1:0] m_fd [2];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_cycle(input bit en, input bit ra, input bit pr, input bit ud,
                             input bit db, input bit we, input bit re);
    bit c_exp;
    bit busy_exp;
    c_exp = en && !ra && !pr && (ud ? (m_addr == 7) : (m_addr == 0));
    for (int d = 0; d < 2; d++) begin
      busy_exp = (cyc > last_rd) && (cyc <= last_rd + lat(d) + 1);
      check($sformatf("mem_addr[%0d]", d),  32'(addr_o[d]), 32'(m_addr));
      check($sformatf("c_out[%0d]", d),     32'(cout_o[d]), 32'(c_exp));
      check($sformatf("mem_wdata[%0d]", d), 32'(wd_o[d]),   db ? 32'hFF : 32'h00);
      check($sformatf("mem_we[%0d]", d),    32'(we_o[d]),   32'(en && we));
      check($sformatf("mem_re[%0d]", d),    32'(re_o[d]),   32'(en && re));
      check($sformatf("error[%0d]", d),     32'(err_o[d]),  32'(exp_err[d][cyc]));
      check($sformatf("cmp_busy[%0d]", d),  32'(busy_o[d]), 32'(busy_exp));
`ifdef BIST_FAIL_LOG_EN
      if (exp_err[d][cyc] && !m_fv[d]) begin
        m_fv[d] = 1'b1;
        m_fa[d] = ea[d][cyc];
        m_fd[d] = ed[d][cyc];
      end
      check($sformatf("fail_valid[%0d]", d), 32'(fv_o[d]), 32'(m_fv[d]));
      check($sformatf("fail_addr[%0d]", d),  32'(fa_o[d]), 32'(m_fa[d]));
      check($sformatf("fail_data[%0d]", d),  32'(fd_o[d]), 32'(m_fd[d]));
`endif
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model after the edge.
  task automatic step(input bit en, input bit ra, input bit pr, input bit ud,
                      input bit db, input bit we, input bit re);
    logic [DW-1:0] rv;
    logic [DW-1:0] pat;
    enable = en; rst_adr = ra; pr_res_adr = pr; up_down = ud;
    data_bit = db; wr_en = we; read_en = re;
    @(negedge clk);
    check_cycle(en, ra, pr, ud, db, we, re);
    @(posedge clk);
    #1;
    pat = db ? 8'hFF : 8'h00;
    if (en && re) begin
      rv = faulty(ref_mem[m_addr], m_addr);
      for (int d = 0; d < 2; d++) begin
        exp_err[d][cyc + lat(d) + 1] = (rv != pat);
        ea[d][cyc + lat(d) + 1]      = AW'(m_addr);
        ed[d][cyc + lat(d) + 1]      = rv;
      end
      last_rd = cyc;
    end
    if (en && we) ref_mem[m_addr] = pat;
    if (ra)      m_addr = 0;
    else if (pr) m_addr = 7;
    else if (en) m_addr = ud ? (m_addr + 1) % 8 : (m_addr + 7) % 8;
    cyc++;
  endtask

  // Asynchronous reset pulse between edges; state must clear before the next edge.
  task automatic pulse_rst();
    enable = 0; rst_adr = 0; pr_res_adr = 0; wr_en = 0; read_en = 0;
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_addr[%0d]", d),  32'(addr_o[d]), 32'd0);
      check($sformatf("rst_error[%0d]", d), 32'(err_o[d]),  32'd0);
      check($sformatf("rst_busy[%0d]", d),  32'(busy_o[d]), 32'd0);
`ifdef BIST_FAIL_LOG_EN
      check($sformatf("rst_fail_valid[%0d]", d), 32'(fv_o[d]), 32'd0);
`endif
      m_fv[d] = 1'b0; m_fa[d] = '0; m_fd[d] = '0;
      for (int k = cyc; k < cyc + 8; k++) exp_err[d][k] = 1'b0;
    end
    m_addr  = 0;
    last_rd = -1000;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_pass(input seq_state_e s);
    bit ud, db, we, re;
    ud = 1'b0; db = 1'b0; we = 1'b0; re = 1'b0;
    case (s)
      WR_UP:     begin ud = 1'b1; db = 1'b0; we = 1'b1; end
      READ_DOWN: begin ud = 1'b0; db = 1'b0; re = 1'b1; end
      WR_DOWN:   begin ud = 1'b0; db = 1'b1; we = 1'b1; end
      READ_UP:   begin ud = 1'b1; db = 1'b1; re = 1'b1; end
      default:   ;
    endcase
    if (s == STANDBY) begin
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);
    end else begin
      if (ud) step(0, 1, 0, ud, db, 0, 0);
      else    step(0, 0, 1, ud, db, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 0, 0, ud, db, we, re);
    end
  endtask

  task automatic march();
    run_pass(WR_UP);
    run_pass(READ_DOWN);
    run_pass(WR_DOWN);
    run_pass(READ_UP);
    run_pass(STANDBY);
  endtask

  initial begin
    rst = 1'b1;
    enable = 0; rst_adr = 0; pr_res_adr = 0; up_down = 0; data_bit = 0; wr_en = 0; read_en = 0;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = '0; sa0[i] = '0; sa1[i] = '0;
    end
    for (int d = 0; d < 2; d++) begin
      m_fv[d] = 1'b0; m_fa[d] = '0; m_fd[d] = '0;
    end
    m_addr = 0; cyc = 0; last_rd = -1000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_addr[%0d]", d),  32'(addr_o[d]), 32'd0);
      check($sformatf("reset_error[%0d]", d), 32'(err_o[d]),  32'd0);
      check($sformatf("reset_busy[%0d]", d),  32'(busy_o[d]), 32'd0);
      check($sformatf("reset_c_out[%0d]", d), 32'(cout_o[d]), 32'd0);
      check($sformatf("reset_fail_valid[%0d]", d), 32'(fv_o[d]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // count up to 5, then asynchronous reset mid-count
    step(0, 1, 0, 1, 0, 0, 0);
    repeat (5) step(1, 0, 0, 1, 0, 0, 0);
    pulse_rst();

    // full up-count with wrap past MAX
    step(0, 1, 0, 1, 0, 0, 0);
    repeat (9) step(1, 0, 0, 1, 0, 0, 0);

    // reset/preset priority, then a full down-count with wrap
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    repeat (9) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // marches: fault-free, stuck-at-1 bit 3 @4, add stuck-at-0 bit 0 @6, add adjacent faults @1,@2
    march();
    sa1[4] = 8'h08;
    march();
    sa0[6] = 8'h01;
    march();
    sa1[1] = 8'h80;
    sa1[2] = 8'h80;
    march();

    // reset while mismatching compares are still in flight
    step(0, 0, 1, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 0, 1);
    pulse_rst();

    // randomized strobes with a few random faults and one mid-run reset
    sa0[$urandom_range(0, 7)] = 8'(1 << $urandom_range(0, 7));
    sa1[$urandom_range(0, 7)] = 8'(1 << $urandom_range(0, 7));
    for (int i = 0; i < 400; i++) begin
      int op;
      if (i == 200) pulse_rst();
      op = $urandom_range(0, 2);
      step($urandom_range(0, 9) < 8, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op == 1, op == 2);
    end
    run_pass(STANDBY);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
